// File: rtl/plzwork_pkg.sv
// Shared definitions for the plzwork AXI4-Lite register block: map offsets,
// ID constant, response codes, FSM state encodings and write-beat payload.
package plzwork_pkg;

    localparam int unsigned REG_W       = 32;
    localparam int unsigned STRB_W      = REG_W / 8;
    localparam int unsigned NUM_RW_REGS = 4;

    localparam logic [31:0] REG0_OFF     = 32'h0000_0000;
    localparam logic [31:0] REG1_OFF     = 32'h0000_0004;
    localparam logic [31:0] REG2_OFF     = 32'h0000_0008;
    localparam logic [31:0] REG3_OFF     = 32'h0000_000C;
    localparam logic [31:0] WR_COUNT_OFF = 32'h0000_0010;
    localparam logic [31:0] ID_OFF       = 32'h0000_0014;
    localparam logic [31:0] ID_VALUE     = 32'h504C_5A57;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_HAVE_AW = 2'd1,
        WR_HAVE_W  = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

    // One write-data beat as captured from the W channel
    typedef struct packed {
        logic [REG_W-1:0]  data;
        logic [STRB_W-1:0] strb;
    } wr_beat_t;

    // Byte address to word-aligned offset (low two bits ignored)
    function automatic logic [31:0] word_offset(input logic [31:0] byte_addr);
        return byte_addr & ~32'h0000_0003;
    endfunction

    // Merge new data into old data on the byte lanes selected by strb
    function automatic logic [REG_W-1:0] merge_lanes(
        input logic [REG_W-1:0]  old_val,
        input logic [REG_W-1:0]  new_val,
        input logic [STRB_W-1:0] strb
    );
        logic [REG_W-1:0] res;
        res = old_val;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/plzwork_axil_regs.sv
// AXI4-Lite slave exposing four RW registers, a write-commit counter and a
// read-only ID word. Independent write and read FSMs; all handshake and
// response outputs are registered.
module plzwork_axil_regs
    import plzwork_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,

    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [2:0]                s_axi_awprot,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,

    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,

    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,

    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [2:0]                s_axi_arprot,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,

    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready
);

    // Protection bits carry no meaning for this block
    logic unused_prot_c;
    assign unused_prot_c = ^{s_axi_awprot, s_axi_arprot};

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    logic [REG_W-1:0] regs_q [NUM_RW_REGS];
    logic [REG_W-1:0] wr_count_q;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    wr_state_t               wr_state_q, wr_state_d;
    logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d;
    wr_beat_t                w_beat_q, w_beat_d;
    wr_beat_t                in_beat_c;

    logic                    commit_c;
    logic [ADDR_WIDTH-1:0]   commit_addr_c;
    wr_beat_t                commit_beat_c;
    logic [31:0]             commit_off_c;
    logic                    commit_rw_c;
    logic [1:0]              commit_idx_c;

    logic                    aw_hs_c, w_hs_c;
    logic                    awready_d, wready_d, bvalid_d;
    logic [1:0]              bresp_d;

    assign aw_hs_c   = s_axi_awvalid & s_axi_awready;
    assign w_hs_c    = s_axi_wvalid  & s_axi_wready;
    assign in_beat_c = '{data: REG_W'(s_axi_wdata), strb: STRB_W'(s_axi_wstrb)};

    // Write FSM next state, AW/W capture, commit decode and next outputs
    always_comb begin
        wr_state_d    = wr_state_q;
        aw_addr_d     = aw_addr_q;
        w_beat_d      = w_beat_q;
        commit_c      = 1'b0;
        commit_addr_c = aw_addr_q;
        commit_beat_c = w_beat_q;

        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs_c && w_hs_c) begin
                    commit_c      = 1'b1;
                    commit_addr_c = s_axi_awaddr;
                    commit_beat_c = in_beat_c;
                    wr_state_d    = WR_RESP;
                end else if (aw_hs_c) begin
                    aw_addr_d  = s_axi_awaddr;
                    wr_state_d = WR_HAVE_AW;
                end else if (w_hs_c) begin
                    w_beat_d   = in_beat_c;
                    wr_state_d = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: begin
                if (w_hs_c) begin
                    commit_c      = 1'b1;
                    commit_addr_c = aw_addr_q;
                    commit_beat_c = in_beat_c;
                    wr_state_d    = WR_RESP;
                end
            end
            WR_HAVE_W: begin
                if (aw_hs_c) begin
                    commit_c      = 1'b1;
                    commit_addr_c = s_axi_awaddr;
                    commit_beat_c = w_beat_q;
                    wr_state_d    = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_axi_bready) begin
                    wr_state_d = WR_IDLE;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase

        commit_off_c = word_offset(32'(commit_addr_c));
        commit_rw_c  = commit_c && (commit_off_c < WR_COUNT_OFF);
        commit_idx_c = commit_off_c[3:2];

        awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_W);
        wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_AW);
        bvalid_d  = (wr_state_d == WR_RESP);
        bresp_d   = commit_c ? (commit_rw_c ? RESP_OKAY : RESP_SLVERR) : s_axi_bresp;
    end

    // Write FSM state, captured AW/W and registered write-channel outputs
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_q    <= WR_IDLE;
            aw_addr_q     <= '0;
            w_beat_q      <= '0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
        end else begin
            wr_state_q    <= wr_state_d;
            aw_addr_q     <= aw_addr_d;
            w_beat_q      <= w_beat_d;
            s_axi_awready <= awready_d;
            s_axi_wready  <= wready_d;
            s_axi_bvalid  <= bvalid_d;
            s_axi_bresp   <= bresp_d;
        end
    end

    // Register file and commit counter update on a mapped RW commit
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else if (commit_rw_c) begin
            regs_q[commit_idx_c] <= merge_lanes(regs_q[commit_idx_c],
                                                commit_beat_c.data,
                                                commit_beat_c.strb);
            wr_count_q <= wr_count_q + REG_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    rd_state_t               rd_state_q, rd_state_d;
    logic                    ar_hs_c;
    logic [31:0]             rd_off_c;
    logic [REG_W-1:0]        rd_data_c;
    logic [1:0]              rd_resp_c;
    logic                    arready_d, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_d;
    logic [1:0]              rresp_d;

    assign ar_hs_c = s_axi_arvalid & s_axi_arready;

    // Read address decode against current (pre-commit) register contents
    always_comb begin
        rd_off_c  = word_offset(32'(s_axi_araddr));
        rd_data_c = '0;
        rd_resp_c = RESP_OKAY;
        if (rd_off_c < WR_COUNT_OFF) begin
            rd_data_c = regs_q[rd_off_c[3:2]];
        end else if (rd_off_c == WR_COUNT_OFF) begin
            rd_data_c = wr_count_q;
        end else if (rd_off_c == ID_OFF) begin
            rd_data_c = ID_VALUE;
        end else begin
            rd_resp_c = RESP_SLVERR;
        end
    end

    // Read FSM next state and next registered read-channel outputs
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = s_axi_rdata;
        rresp_d    = s_axi_rresp;

        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs_c) begin
                    rdata_d    = DATA_WIDTH'(rd_data_c);
                    rresp_d    = rd_resp_c;
                    rd_state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (s_axi_rready) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase

        arready_d = (rd_state_d == RD_IDLE);
        rvalid_d  = (rd_state_d == RD_RESP);
    end

    // Read FSM state and registered read-channel outputs
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_state_q    <= RD_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            rd_state_q    <= rd_state_d;
            s_axi_arready <= arready_d;
            s_axi_rvalid  <= rvalid_d;
            s_axi_rdata   <= rdata_d;
            s_axi_rresp   <= rresp_d;
        end
    end

endmodule

// File: doc/plzwork_axil_regs.md
PLZWORK_AXIL_REGS -- requirements
Module: plzwork_axil_regs

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, byte-address width of the AXI4-Lite slave port.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-003 SHALL have port ACLK  input  1  single clock; all logic is rising-edge.
REQ-004 SHALL have port ARESETN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have write-address ports: s_axi_awaddr  in  ADDR_WIDTH; s_axi_awprot  in  3 (ignored); s_axi_awvalid  in  1; s_axi_awready  out  1.
REQ-006 SHALL have write-data ports: s_axi_wdata  in  32; s_axi_wstrb  in  4; s_axi_wvalid  in  1; s_axi_wready  out  1.
REQ-007 SHALL have write-response ports: s_axi_bresp  out  2; s_axi_bvalid  out  1; s_axi_bready  in  1.
REQ-008 SHALL have read-address ports: s_axi_araddr  in  ADDR_WIDTH; s_axi_arprot  in  3 (ignored); s_axi_arvalid  in  1; s_axi_arready  out  1.
REQ-009 SHALL have read-data ports: s_axi_rdata  out  32; s_axi_rresp  out  2; s_axi_rvalid  out  1; s_axi_rready  in  1.

Function
REQ-010 SHALL implement this register map on word address (addr[1:0] ignored): 0x00-0x0C REG0-REG3 RW; 0x10 WR_COUNT RO; 0x14 ID RO = 0x504C5A57; 0x18 and above unmapped.
REQ-011 Write FSM SHALL have states WR_IDLE, WR_HAVE_AW, WR_HAVE_W, WR_RESP.
REQ-012 In WR_IDLE, awready=1 and wready=1; AW and W handshake independently.
REQ-013 If AW and W handshake in the same cycle in WR_IDLE, the write SHALL commit on that edge; next state WR_RESP.
REQ-014 If only AW handshakes, the address SHALL be latched; next state WR_HAVE_AW (awready=0, wready=1). If only W handshakes, data and strobes SHALL be latched; next state WR_HAVE_W (awready=1, wready=0). The write commits on the completing handshake; next state WR_RESP.
REQ-015 In WR_RESP, bvalid=1 and awready=wready=0; bresp and bvalid SHALL be held stable until bready=1; then next state WR_IDLE.
REQ-016 Write commit to REG0-3 SHALL update each byte lane i only where wstrb[i]=1; bresp=OKAY (2'b00).
REQ-017 A commit to REG0-3 SHALL increment WR_COUNT by 1 (32-bit, wraps 0xFFFFFFFF->0); a wstrb=0 commit still counts.
REQ-018 A write to RO or unmapped addresses SHALL change no state, SHALL NOT count, and SHALL return bresp=SLVERR (2'b10).
REQ-019 Read FSM SHALL have states RD_IDLE (arready=1, rvalid=0) and RD_RESP (arready=0, rvalid=1).
REQ-020 On AR handshake, rdata/rresp SHALL be registered that edge and rvalid asserted the next cycle (latency 1); held stable until rready=1, then RD_IDLE.
REQ-021 Unmapped reads SHALL return rdata=0, rresp=SLVERR; mapped reads return rresp=OKAY.
REQ-022 Read and write FSMs SHALL run concurrently; a read captured on the same edge a write commits to the same register SHALL return the pre-write value.
REQ-023 A read of WR_COUNT captured on a commit edge SHALL return the pre-increment value.

Reset
REQ-024 ARESETN low SHALL asynchronously force: both FSMs to IDLE, REG0-3=0, WR_COUNT=0, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, awready=wready=arready=0.
REQ-025 Ready outputs SHALL rise no earlier than the first ACLK edge after ARESETN deasserts.
REQ-026 Reset mid-transaction SHALL discard latched AW/W and pending responses with no register update.

Structure
REQ-027 Register offsets, ID constant, resp codes (OKAY, SLVERR) and FSM state enums SHALL live in shared package plzwork_pkg.
REQ-028 No sub-module is required; write path and read path SHALL be separate always blocks within plzwork_axil_regs.

Verification
REQ-029 Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, then read each -> 0x1..0x4, all OKAY; WR_COUNT read -> 0x4.
REQ-030 REG1=0xAABBCCDD, write 0x11223344 wstrb=4'b0101 -> read 0xAA22CC44.
REQ-031 W presented 3 cycles before AW -> wready drops after W handshake, bvalid rises 1 cycle after AW handshake; bready held low 5 cycles -> bvalid/bresp stable throughout.
REQ-032 Write 0x14 and 0x20 -> bresp=SLVERR, ID still 0x504C5A57, WR_COUNT unchanged; read 0x20 -> rdata=0, rresp=SLVERR.
REQ-033 Same-cycle AR and AW+W to 0x08 (old 0x3, new 0x9) -> rdata=0x3; subsequent read -> 0x9.
REQ-034 ARESETN pulsed low while in WR_HAVE_AW and RD_RESP -> bvalid=rvalid=0 immediately, REG0-3 read 0 after reset.
